// File: rtl/qlm_acc_pkg.sv
// Shared types, default widths and saturation-limit helper for the qlm_dot_acc accumulator.
package qlm_acc_pkg;

  localparam int ACC_W_DEF = 40;
  localparam int LEN_W_DEF = 8;
  localparam int SAT_MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Largest positive (neg=0) or most negative (neg=1) w-bit signed value, filled out to SAT_MAX_W bits.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned w, input logic neg);
    logic [SAT_MAX_W-1:0] one;
    logic [SAT_MAX_W-1:0] pos;
    one = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    pos = (one << (w - 32'd1)) - one;
    if (neg) begin
      return ~pos;
    end else begin
      return pos;
    end
  endfunction

endpackage

// File: rtl/qlm_sat_add.sv
// ACC_W-bit signed adder with carry-in and overflow detect; QLM_ACC_SAT_EN adds clamping to the signed limits.
module qlm_sat_add
  import qlm_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             cin,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  // One guard bit holds the exact a+b+cin; overflow is the guard disagreeing with the ACC_W sign bit.
  logic [ACC_W:0] ext;
  logic           ovf_raw;

  assign ext     = {a[ACC_W-1], a} + {b[ACC_W-1], b} + {{ACC_W{1'b0}}, cin};
  assign ovf_raw = ext[ACC_W] ^ ext[ACC_W-1];
  assign ovf     = ovf_raw;

`ifdef QLM_ACC_SAT_EN
  localparam logic [ACC_W-1:0] POS_LIM = ACC_W'(sat_limit(ACC_W, 1'b0));
  localparam logic [ACC_W-1:0] NEG_LIM = ACC_W'(sat_limit(ACC_W, 1'b1));

  // Clamp toward the sign of the exact result when it leaves the ACC_W range.
  always_comb begin
    if (ovf_raw) begin
      sum = ext[ACC_W] ? NEG_LIM : POS_LIM;
    end else begin
      sum = ext[ACC_W-1:0];
    end
  end
`else
  assign sum = ext[ACC_W-1:0];
`endif

endmodule

// File: rtl/qlm_dot_acc.sv
// Streaming dot-product accumulator for the log-multiplier product stream.
// Build macro QLM_ACC_SAT_EN selects saturating accumulation with a sticky overflow flag.
module qlm_dot_acc
  import qlm_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      prod_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic             out_ovf_o,
  output logic             busy_o
);

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W:0]   cnt;
  logic [LEN_W:0]   len_q;
  logic [LEN_W:0]   len_eff;
  logic [LEN_W:0]   cnt_inc;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] term_b;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             beat;

  assign beat    = in_valid_i & in_ready_o;
  assign len_eff = (len_i == {LEN_W{1'b0}}) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_i};
  assign cnt_inc = cnt + CNT_ONE;
  // The first beat of a dot product starts from zero rather than the stale sum.
  assign add_a   = (state == IDLE) ? {ACC_W{1'b0}} : acc;
  // One's-complement negatives become two's complement through the adder carry-in.
  assign term_b  = {{(ACC_W-32){prod_i[31]}}, prod_i};

  qlm_sat_add #(.ACC_W(ACC_W)) u_add (
    .a   (add_a),
    .b   (term_b),
    .cin (prod_i[31]),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Control FSM with accumulator, beat counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= {ACC_W{1'b0}};
      cnt         <= {(LEN_W+1){1'b0}};
      len_q       <= {(LEN_W+1){1'b0}};
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            acc    <= add_sum;
            cnt    <= CNT_ONE;
            len_q  <= len_eff;
            busy_o <= 1'b1;
            if (len_eff == CNT_ONE) begin
              state       <= HOLD;
              in_ready_o  <= 1'b0;
              out_valid_o <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (beat) begin
            acc <= add_sum;
            cnt <= cnt_inc;
            if (cnt_inc == len_q) begin
              state       <= HOLD;
              in_ready_o  <= 1'b0;
              out_valid_o <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            state       <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data_o = acc;

`ifdef QLM_ACC_SAT_EN
  logic ovf;

  // Sticky overflow flag, cleared by the first beat of each dot product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (beat && (state == IDLE)) begin
      ovf <= 1'b0;
    end else if (beat) begin
      ovf <= ovf | add_ovf;
    end else begin
      ovf <= ovf;
    end
  end

  assign out_ovf_o = ovf;
`else
  logic add_ovf_unused;
  assign add_ovf_unused = add_ovf;
  assign out_ovf_o      = 1'b0;
`endif

endmodule

// File: tb/tb_qlm_dot_acc.sv
// Self-checking bench for qlm_dot_acc: directed scenarios plus randomized dot products against an integer model.
module tb_qlm_dot_acc;

  localparam int ACC_W = 33;
  localparam int LEN_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [LEN_W-1:0] len_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      prod_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [ACC_W-1:0] out_data_o;
  logic             out_ovf_o;
  logic             busy_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  qlm_dot_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .len_i       (len_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .prod_i      (prod_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_ovf_o   (out_ovf_o),
    .busy_o      (busy_o)
  );

  // Reference: products are one's-complement integers, summed exactly; clamped when saturation is built in.
  function automatic void model(input logic [31:0] q[$], output logic [ACC_W-1:0] d, output logic o);
    longint acc;
    longint term;
    longint lim;
    lim = longint'(1) << (ACC_W - 1);
    acc = 0;
    o   = 1'b0;
    foreach (q[i]) begin
      term = longint'($signed(q[i]));
      if (q[i][31]) term = term + 1;
      acc = acc + term;
`ifdef QLM_ACC_SAT_EN
      if (acc > lim - 1) begin
        acc = lim - 1;
        o   = 1'b1;
      end else if (acc < -lim) begin
        acc = -lim;
        o   = 1'b1;
      end
`endif
    end
    d = acc[ACC_W-1:0];
  endfunction

  task automatic send(input logic [31:0] p, input logic [LEN_W-1:0] len);
    int t;
    in_valid_i = 1'b1;
    prod_i     = p;
    len_i      = len;
    t = 0;
    while (!in_ready_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready_o) begin
      total++;
      $display("FAIL send_timeout: in_ready_o=%0b after 50 cycles, expected 1", in_ready_o);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic collect(input int delay, output logic [ACC_W-1:0] d, output logic o);
    int t;
    t = 0;
    while (!out_valid_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid_o) begin
      total++;
      $display("FAIL collect_timeout: out_valid_o=%0b after 50 cycles, expected 1", out_valid_o);
    end
    repeat (delay) begin
      @(posedge clk); #1;
    end
    d = out_data_o;
    o = out_ovf_o;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; prod_i = 32'h0; len_i = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({in_ready_o, out_valid_o, out_ovf_o, busy_o} !== 4'b1000) $display("FAIL reset_ctrl: got rdy/vld/ovf/busy=%b, expected 1000", {in_ready_o, out_valid_o, out_ovf_o, busy_o});
    else passed++;
    total++;
    if (out_data_o !== {ACC_W{1'b0}}) $display("FAIL reset_data: got %h, expected 0", out_data_o);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    out_ready_i = 1'b1;
    send(32'h0000_0064, 2'd1);
    total++;
    if (out_valid_o !== 1'b1 || out_data_o !== 33'd100 || out_ovf_o !== 1'b0) $display("FAIL single: got vld=%b data=%0d ovf=%b, expected 1/100/0", out_valid_o, out_data_o, out_ovf_o);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) $display("FAIL single_idle: got vld=%b busy=%b rdy=%b, expected 0/0/1", out_valid_o, busy_o, in_ready_o);
    else passed++;
    out_ready_i = 1'b0;
  endtask

  task automatic test_sign();
    logic [ACC_W-1:0] d;
    logic o;
    send(32'h0000_000A, 2'd3);
    total++;
    if (busy_o !== 1'b1 || out_valid_o !== 1'b0) $display("FAIL sign_busy: got busy=%b vld=%b, expected 1/0", busy_o, out_valid_o);
    else passed++;
    send(32'hFFFF_FFF5, 2'd1);
    send(32'h0000_0005, 2'd2);
    total++;
    if (out_valid_o !== 1'b1) $display("FAIL sign_latency: got out_valid_o=%b, expected 1", out_valid_o);
    else passed++;
    collect(0, d, o);
    total++;
    if (d !== 33'd5) $display("FAIL sign_sum: got %0d, expected 5", $signed(d));
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] d;
    logic o;
    send(32'h0000_0003, 2'd2);
    send(32'h0000_0004, 2'd2);
    in_valid_i = 1'b1; prod_i = 32'h0000_0055; len_i = 2'd1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid_o !== 1'b1 || out_data_o !== 33'd7 || in_ready_o !== 1'b0) $display("FAIL backpressure_hold%0d: got vld=%b data=%0d rdy=%b, expected 1/7/0", i, out_valid_o, out_data_o, in_ready_o);
      else passed++;
      @(posedge clk); #1;
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL backpressure_release: got vld=%b rdy=%b busy=%b, expected 0/1/0", out_valid_o, in_ready_o, busy_o);
    else passed++;
    send(32'h0000_0009, 2'd1);
    collect(0, d, o);
    total++;
    if (d !== 33'd9) $display("FAIL backpressure_next: got %0d, expected 9", d);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] d;
    logic o;
    logic [ACC_W-1:0] exp_d;
    logic exp_o;
`ifdef QLM_ACC_SAT_EN
    exp_d = 33'h0_FFFF_FFFF; exp_o = 1'b1;
`else
    exp_d = 33'h1_7FFF_FFFD; exp_o = 1'b0;
`endif
    repeat (3) send(32'h7FFF_FFFF, 2'd3);
    collect(1, d, o);
    total++;
    if (d !== exp_d || o !== exp_o) $display("FAIL overflow: got data=%h ovf=%b, expected %h/%b", d, o, exp_d, exp_o);
    else passed++;
    send(32'h0000_0001, 2'd1);
    collect(0, d, o);
    total++;
    if (d !== 33'd1 || o !== 1'b0) $display("FAIL overflow_clear: got data=%h ovf=%b, expected 1/0", d, o);
    else passed++;
  endtask

  task automatic test_zero_len_reset();
    logic [ACC_W-1:0] d;
    logic o;
    for (int i = 0; i < 3; i++) send(32'h0000_0001, 2'd0);
    total++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL zerolen_partial: got vld=%b busy=%b, expected 0/1", out_valid_o, busy_o);
    else passed++;
    send(32'h0000_0001, 2'd0);
    collect(0, d, o);
    total++;
    if (d !== 33'd4) $display("FAIL zerolen_sum: got %0d, expected 4", d);
    else passed++;
    send(32'h0000_0001, 2'd0);
    send(32'h0000_0001, 2'd0);
    rst = 1'b1;
    #2;
    total++;
    if ({in_ready_o, out_valid_o, out_ovf_o, busy_o} !== 4'b1000 || out_data_o !== {ACC_W{1'b0}}) $display("FAIL midreset: got rdy/vld/ovf/busy=%b data=%h, expected 1000/0", {in_ready_o, out_valid_o, out_ovf_o, busy_o}, out_data_o);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'h0000_0007, 2'd1);
    collect(0, d, o);
    total++;
    if (d !== 33'd7 || o !== 1'b0) $display("FAIL after_reset: got data=%0d ovf=%b, expected 7/0", d, o);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [ACC_W-1:0] exp_d;
    logic exp_o;
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      q = {};
      for (int b = 0; b < 2; b++) begin
        q.push_back($urandom);
        send(q[b], 2'd2);
      end
      model(q, exp_d, exp_o);
      total++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || out_data_o !== exp_d || out_ovf_o !== exp_o) $display("FAIL b2b_result%0d: got vld=%b rdy=%b data=%h ovf=%b, expected 1/0/%h/%b", k, out_valid_o, in_ready_o, out_data_o, out_ovf_o, exp_d, exp_o);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) $display("FAIL b2b_dead%0d: got vld=%b rdy=%b, expected 0/1", k, out_valid_o, in_ready_o);
      else passed++;
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] p;
    logic [LEN_W-1:0] len;
    logic [ACC_W-1:0] d;
    logic o;
    logic [ACC_W-1:0] exp_d;
    logic exp_o;
    int n;
    for (int k = 0; k < 40; k++) begin
      len = LEN_W'($urandom_range(0, 3));
      n = (len == 0) ? 4 : int'(len);
      q = {};
      for (int b = 0; b < n; b++) begin
        case ($urandom_range(0, 3))
          0: p = 32'h7FFF_FFFF - $urandom_range(0, 3);
          1: p = 32'h8000_0000 + $urandom_range(0, 3);
          2: p = $urandom_range(0, 255) | ($urandom_range(0, 1) ? 32'hFFFF_FF00 : 32'h0);
          default: p = $urandom;
        endcase
        q.push_back(p);
        repeat ($urandom_range(0, 2)) begin
          prod_i = $urandom; len_i = LEN_W'($urandom);
          @(posedge clk); #1;
        end
        send(p, (b == 0) ? len : LEN_W'($urandom));
      end
      model(q, exp_d, exp_o);
      total++;
      if (out_valid_o !== 1'b1) $display("FAIL rand_latency%0d: got out_valid_o=%b, expected 1", k, out_valid_o);
      else passed++;
      collect($urandom_range(0, 3), d, o);
      total++;
      if (d !== exp_d || o !== exp_o) $display("FAIL rand_result%0d: len=%0d got data=%h ovf=%b, expected %h/%b", k, n, d, o, exp_d, exp_o);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sign();
    test_backpressure();
    test_overflow();
    test_zero_len_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/qlm_dot_acc.md
# qlm_dot_acc

- Streaming dot-product accumulator directly downstream of the 16x16 approximate logarithmic multiplier.
- Consumes the multiplier's 32-bit signed product stream over a valid/ready handshake.
- Converts the multiplier's one's-complement negative products to two's complement and sums a programmable number of them into a wide accumulator.
- Presents each finished sum on a registered output handshake, so the combinational multiplier can be packed into MAC/filter datapaths.

## Interface
- ACC_W, 40, accumulator and result width (signed), ≥ 33
- LEN_W, 8, width of the product-count field
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- len_i  input  LEN_W  products per dot product; sampled only on the first beat; 0 means 2^LEN_W
- in_valid_i  input  1  prod_i valid
- in_ready_o  output  1  block accepts prod_i
- prod_i  input  32  product from the log multiplier (negative values are one's complement)
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- out_data_o  output  ACC_W  signed dot-product result
- out_ovf_o  output  1  overflow occurred during this dot product
- busy_o  output  1  a dot product is in progress (state ≠ IDLE)

## Operation
- **Beat accepted:** in_valid_i & in_ready_o.
- **Term per beat:** sext(prod_i) + prod_i[31], evaluated at ACC_W bits.
  - The carry-in restores two's complement.
  - A zero product (32'h0) adds 0.
- **IDLE:**
  - in_ready_o=1, out_valid_o=0.
  - On a beat: acc ← term, cnt ← 1, len_q ← (len_i==0 ? 2^LEN_W : len_i), ovf ← 0.
  - Next state: HOLD if len_q==1, else ACC.
- **ACC:**
  - in_ready_o=1.
  - Each beat: acc ← acc + term, cnt ← cnt+1.
  - When the beat makes cnt==len_q, go to HOLD.
  - No beat means no change.
- **HOLD:**
  - in_ready_o=0, out_valid_o=1.
  - out_data_o=acc and out_ovf_o=ovf, both stable while held.
  - When out_ready_i=1, go to IDLE.
- **Counter width:** cnt and len_q are LEN_W+1 bits. No wrap is possible.
- **Overflow flag:** sticky per dot product; cleared only on the first beat of the next dot product.
- **Simultaneous events:** the input cannot be accepted in the same cycle a result is released. In HOLD, in_ready_o=0 regardless of out_ready_i.
- **Reset mid-operation:** the partial sum is discarded. The next dot product starts clean.

## Timing
- **Reset values:**
  - in_ready_o=1, out_valid_o=0, out_data_o=0, out_ovf_o=0, busy_o=0.
  - Internally: state=IDLE, acc=0, cnt=0.
- **Latency:** out_valid_o rises in the cycle after the last beat is accepted.
- **Throughput:** one product per cycle while accumulating. Minimum one dead cycle per dot product (HOLD).
- **Outputs:** all outputs are registered or decoded from state only. There is no combinational path from in_valid_i or out_ready_i to any output.

## Configuration
- **Macro:** QLM_ACC_SAT_EN.
- **Defined:** saturating accumulation.
  - On signed overflow of acc + term, acc clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - ovf is set.
  - Further terms are still added to the clamped value.
- **Undefined:** acc wraps modulo 2^ACC_W. out_ovf_o is tied to 0 and the flag register is removed.

## Structure
- **Package qlm_acc_pkg:**
  - state enum {IDLE, ACC, HOLD}
  - default ACC_W/LEN_W constants
  - function for the ACC_W saturation limits
- **Sub-module qlm_sat_add:**
  - ACC_W-bit signed adder taking a carry-in.
  - Outputs the sum and an overflow bit.
  - Saturation logic lives inside it, under QLM_ACC_SAT_EN.
- **Top:** holds the FSM, counter, registers and handshakes.

## Test plan
- **Single product:** len_i=1, prod_i=32'h0000_0064, out_ready_i=1 → out_valid_o=1 exactly one cycle later, out_data_o=100, ovf=0, then back to IDLE.
- **Sign correction:** len_i=3, beats 32'h0000_000A, 32'hFFFF_FFF5, 32'h0000_0005 on consecutive cycles → out_data_o=5; the middle term contributes -10.
- **Backpressure:** after the last beat, hold out_ready_i=0 for 5 cycles while in_valid_i=1 → out_valid_o stays 1, out_data_o stable, in_ready_o=0, no beat consumed. The release cycle returns to IDLE.
- **Overflow, ACC_W=33, len_i=3, three beats of 32'h7FFF_FFFF:**
  - With QLM_ACC_SAT_EN: out_data_o=33'h0_FFFF_FFFF, out_ovf_o=1.
  - Without it: out_data_o=33'h1_7FFF_FFFD, out_ovf_o=0.
- **Zero length and reset:** with LEN_W=2, len_i=0, four beats of 1 → out_data_o=4. Assert rst after 2 of 4 beats → all outputs at reset values; the next len_i=1 beat of 7 yields 7.
